// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_pkg: mode encoding shared by the LED pattern generator files
package led_pattern_pkg;
   localparam int MODE_W = 2;
   typedef enum logic [MODE_W-1:0] {OFF, ON, BLINK, BREATHE} led_mode_e;
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: one-word valid/ready configuration port
// cfg_valid/cfg_ready handshake; cfg_ch target channel, cfg_mode led_mode_e, cfg_rate step period minus one
interface led_pattern_gen_if #(
   parameter int CH_W = 2,
   parameter int RATE_W = 16
);
   logic cfg_valid;
   logic cfg_ready;
   logic [CH_W-1:0] cfg_ch;
   logic [led_pattern_pkg::MODE_W-1:0] cfg_mode;
   logic [RATE_W-1:0] cfg_rate;
   modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_rate, input cfg_ready);
   modport slave (input cfg_valid, cfg_ch, cfg_mode, cfg_rate, output cfg_ready);
endinterface

// File: rtl/led_pattern_gen_channel.sv
// led_channel: one LED output with divider, blink phase and triangle-ramped PWM duty
// clk/rst_n; load strobe with mode_in/rate_in; shared pwm_cnt; registered led
module led_channel import led_pattern_pkg::*; #(
   parameter int RATE_W = 16,
   parameter int PWM_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  led_mode_e mode_in,
   input  logic [RATE_W-1:0] rate_in,
   input  logic [PWM_W-1:0] pwm_cnt,
   output logic led
);
   localparam logic [PWM_W-1:0] DMAX = '1;
   led_mode_e mode, mode_n;
   logic [RATE_W-1:0] rate, div, div_n;
   logic [PWM_W-1:0] duty, duty_n;
   logic phase, phase_n, dn, dn_n, run, step, bstep, top, bot, led_n;
   // led is computed from the next-state values so it changes on the same edge as the state
   always_comb begin
      mode_n = load ? mode_in : mode;
      run = mode == BLINK || mode == BREATHE;
      step = run && div == rate;
      bstep = step && mode == BREATHE;
      top = !dn && duty == DMAX;
      bot = dn && duty == '0;
      div_n = (load || !run || step) ? '0 : div + RATE_W'(1);
      phase_n = load ? 1'b0 : phase ^ (step && mode == BLINK);
      dn_n = load ? 1'b0 : dn ^ (bstep && (top || bot));
      duty_n = load ? '0 : !bstep ? duty : top ? DMAX - PWM_W'(1) : bot ? PWM_W'(1) : dn ? duty - PWM_W'(1) : duty + PWM_W'(1);
      led_n = mode_n == ON || (mode_n == BLINK && phase_n) || (mode_n == BREATHE && duty_n > pwm_cnt);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mode <= OFF;
         rate <= '0;
         div <= '0;
         duty <= '0;
         phase <= 1'b0;
         dn <= 1'b0;
         led <= 1'b0;
      end else begin
         mode <= mode_n;
         rate <= load ? rate_in : rate;
         div <= div_n;
         duty <= duty_n;
         phase <= phase_n;
         dn <= dn_n;
         led <= led_n;
      end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with off/on/blink/breathe modes
// clk, rst_n (async active-low); cfg slave port; led[CHANNELS] active-high
module led_pattern_gen import led_pattern_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int RATE_W = 16,
   parameter int PWM_W = 8,
   localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic clk,
   input  logic rst_n,
   led_pattern_gen_if.slave cfg,
   output logic [CHANNELS-1:0] led
);
   typedef enum logic {IDLE, APPLY} state_e;
   state_e state;
   logic ready;
   logic [CH_W-1:0] w_ch;
   led_mode_e w_mode;
   logic [RATE_W-1:0] w_rate;
   logic [PWM_W-1:0] pwm_cnt;
   assign cfg.cfg_ready = ready;
   // ready comes up one edge after reset release, so nothing is taken on that first edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ready <= 1'b0;
         w_ch <= '0;
         w_mode <= OFF;
         w_rate <= '0;
      end else if (state == IDLE) begin
         ready <= !(cfg.cfg_valid && ready);
         if (cfg.cfg_valid && ready) begin
            state <= APPLY;
            w_ch <= cfg.cfg_ch;
            w_mode <= led_mode_e'(cfg.cfg_mode);
            w_rate <= cfg.cfg_rate;
         end
      end else begin
         state <= IDLE;
         ready <= 1'b1;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt + PWM_W'(1);
   // out-of-range channel numbers match no instance, so the write is dropped
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      led_channel #(.RATE_W(RATE_W), .PWM_W(PWM_W)) u_ch (
         .clk(clk),
         .rst_n(rst_n),
         .load(state == APPLY && w_ch == CH_W'(i)),
         .mode_in(w_mode),
         .rate_in(w_rate),
         .pwm_cnt(pwm_cnt),
         .led(led[i])
      );
   end
endmodule
